core_ctrl: RTL and testbench
============================

// Module: core_ctrl
// PURPOSE
//  Pipeline sequencer between the execute stage and the fetch/decode registers.
//  Merges jump requests from execute, the execute-stage hold, and the bus-arbiter hold.
//  Drives the PC redirect, pipeline flush and hold level.
//  Defers a jump that arrives while the bus stalls the PC, and watches for hung holds.
// PARAMETERS
//  FLUSH_CYCLES  1     extra cycles flush_out stays high after the redirect cycle (0..15)
//  HOLD_TIMEOUT  1024  consecutive held cycles before hold_timeout_out sets (>=2)
// PORTS
//  clk               in   1   core clock, rising edge
//  rst               in   1   asynchronous reset, active-low
//  jump_flag_in      in   1   execute requests redirect (JAL/JALR/taken branch)
//  jump_addr_in      in   32  redirect target
//  hold_ex_in        in   1   execute-stage multi-cycle hold request
//  hold_bus_in       in   1   bus arbiter hold request (PC/fetch cannot advance)
//  timeout_clr_in    in   1   clears hold_timeout_out
//  jump_flag_out     out  1   redirect PC this cycle
//  jump_addr_out     out  32  redirect target to PC
//  flush_out         out  1   invalidate if_id/id_ex contents
//  hold_flag_out     out  3   0=HoldNone 1=HoldPc 2=HoldIf 3=HoldId
//  hold_timeout_out  out  1   sticky: a hold exceeded HOLD_TIMEOUT
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=S_RUN; pending jump and counters cleared.
//   - All outputs 0; jump_addr_out=CPURstAddress.
//  FSM states: S_RUN, S_FLUSH, S_JPEND.
//  S_RUN:
//   - jump_flag_in & !hold_bus_in: jump_flag_out=1, jump_addr_out=jump_addr_in, flush_out=1.
//     These outputs are combinational (zero latency).
//     Next state: S_FLUSH if FLUSH_CYCLES>0, else S_RUN.
//   - jump_flag_in & hold_bus_in: latch jump_addr_in into pend_addr; jump_flag_out=0;
//     flush_out=1; next S_JPEND.
//  S_FLUSH:
//   - flush_out=1 for FLUSH_CYCLES cycles (down-counter), then return to S_RUN.
//   - A new jump_flag_in here is handled exactly as in S_RUN; the counter reloads.
//  S_JPEND:
//   - flush_out=1 and hold_flag_out>=HoldPc while hold_bus_in=1.
//   - First cycle hold_bus_in=0: jump_flag_out=1 with pend_addr, then go to S_FLUSH
//     (or S_RUN if FLUSH_CYCLES=0).
//   - Further jump_flag_in while in S_JPEND is ignored; the younger instruction is
//     already flushed.
//  Hold level (combinational, highest wins):
//   - hold_ex_in -> HoldId; hold_bus_in or S_JPEND -> HoldPc; otherwise HoldNone.
//   - The jump cycle in S_RUN outputs HoldNone unless hold_ex_in is high. If hold_ex_in
//     is high, the jump is still issued and hold is HoldId.
//  Watchdog:
//   - 16-bit held-cycle counter increments while hold_flag_out!=HoldNone.
//   - Clears on any HoldNone cycle; saturates at HOLD_TIMEOUT.
//   - Reaching HOLD_TIMEOUT sets hold_timeout_out on the next edge.
//   - timeout_clr_in clears the flag and wins over a simultaneous set.
// CONFIGURATION
//  CORE_CTRL_PERF_EN defined: adds 32-bit wrapping counters and their output ports
//  (perf_stall_cnt_out, perf_flush_cnt_out, 32 bits each, reset 0):
//   - perf_stall_cnt_out counts cycles with hold_flag_out!=HoldNone.
//   - perf_flush_cnt_out counts jump_flag_out pulses.
//  CORE_CTRL_PERF_EN undefined: no counters, ports absent, otherwise identical.
// TESTING
//  1. Reset: rst=0 mid-S_FLUSH
//     -> all outputs 0 immediately (async); state S_RUN after rst=1.
//  2. Plain jump: jump_flag_in=1, addr=0x0000_0040, no holds, FLUSH_CYCLES=1
//     -> same cycle jump_flag_out=1, addr 0x40, flush=1; next cycle flush=1 jump=0;
//     then idle.
//  3. Deferred jump: hold_bus_in=1 for 3 cycles, jump addr 0x100 in cycle 0
//     -> hold=HoldPc, jump_flag_out=0 for cycles 0-2;
//     cycle 3: jump_flag_out=1, addr 0x100; one pulse only.
//  4. Ex hold + bus hold together -> hold_flag_out=3; drop ex hold -> 1; drop bus -> 0.
//  5. Watchdog: HOLD_TIMEOUT=4, hold_ex_in held 6 cycles
//     -> hold_timeout_out=1 after the 4th held edge; pulse timeout_clr_in -> 0.
//  6. CORE_CTRL_PERF_EN: 2 jumps + 5 held cycles
//     -> perf_flush_cnt_out=2, perf_stall_cnt_out=5.
//     Rebuild without the macro; the test-2 waveform is unchanged.

Source files
------------

// File: rtl/core_ctrl.sv
// Pipeline sequencer: merges execute jumps and holds into PC redirect, flush and hold level.
// Optional CORE_CTRL_PERF_EN adds stall/redirect performance counters and their ports.
module core_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned HOLD_TIMEOUT = 1024,
    parameter logic [31:0] CPU_RST_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_ex_in,
    input  logic        hold_bus_in,
    input  logic        timeout_clr_in,
    output logic        jump_flag_out,
    output logic [31:0] jump_addr_out,
    output logic        flush_out,
    output logic [2:0]  hold_flag_out,
    output logic        hold_timeout_out
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_out,
    output logic [31:0] perf_flush_cnt_out
`endif
);

    localparam int unsigned AW = 32;
    localparam int unsigned HW = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned WW = 16;

    localparam logic [HW-1:0] HOLD_NONE = HW'(0);
    localparam logic [HW-1:0] HOLD_PC   = HW'(1);
    localparam logic [HW-1:0] HOLD_ID   = HW'(3);

    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);
    localparam logic [WW-1:0] TMO_LIMIT  = WW'(HOLD_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_JPEND = 2'd2
    } state_t;

    localparam state_t AFTER_JUMP = (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;

    state_t          state, state_nxt;
    logic [CW-1:0]   flush_cnt, flush_cnt_nxt;
    logic [AW-1:0]   pend_addr, pend_addr_nxt;
    logic [WW-1:0]   held_cnt;
    logic            held_c;
    logic            tmo_set_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            flush_cnt <= '0;
            pend_addr <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            pend_addr <= pend_addr_nxt;
        end
    end

    // Next state plus zero-latency redirect/flush/hold outputs; forced idle while in reset.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pend_addr_nxt = pend_addr;
        jump_flag_out = 1'b0;
        jump_addr_out = CPU_RST_ADDR;
        flush_out     = 1'b0;
        hold_flag_out = HOLD_NONE;

        case (state)
            S_RUN, S_FLUSH: begin
                if (state == S_FLUSH) begin
                    flush_out = 1'b1;
                    if (flush_cnt <= CW'(1)) begin
                        state_nxt = S_RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - CW'(1);
                    end
                end
                if (jump_flag_in) begin
                    flush_out = 1'b1;
                    if (hold_bus_in) begin
                        pend_addr_nxt = jump_addr_in;
                        state_nxt     = S_JPEND;
                    end else begin
                        jump_flag_out = 1'b1;
                        jump_addr_out = jump_addr_in;
                        flush_cnt_nxt = FLUSH_LOAD;
                        state_nxt     = AFTER_JUMP;
                    end
                end
            end
            S_JPEND: begin
                // Younger jumps are ignored: their instructions are already being flushed.
                flush_out = 1'b1;
                if (!hold_bus_in) begin
                    jump_flag_out = 1'b1;
                    jump_addr_out = pend_addr;
                    flush_cnt_nxt = FLUSH_LOAD;
                    state_nxt     = AFTER_JUMP;
                end
            end
            default: state_nxt = S_RUN;
        endcase

        if (hold_ex_in) begin
            hold_flag_out = HOLD_ID;
        end else if (hold_bus_in || (state == S_JPEND)) begin
            hold_flag_out = HOLD_PC;
        end

        if (!rst) begin
            jump_flag_out = 1'b0;
            jump_addr_out = CPU_RST_ADDR;
            flush_out     = 1'b0;
            hold_flag_out = HOLD_NONE;
        end
    end

    assign held_c    = (hold_flag_out != HOLD_NONE);
    assign tmo_set_c = held_c && (held_cnt >= (TMO_LIMIT - WW'(1)));

    // Hung-hold watchdog: flag sets on the edge that brings the count to the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_cnt         <= '0;
            hold_timeout_out <= 1'b0;
        end else begin
            if (!held_c) begin
                held_cnt <= '0;
            end else if (held_cnt < TMO_LIMIT) begin
                held_cnt <= held_cnt + WW'(1);
            end
            if (timeout_clr_in) begin
                hold_timeout_out <= 1'b0;
            end else if (tmo_set_c) begin
                hold_timeout_out <= 1'b1;
            end
        end
    end

`ifdef CORE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_out <= '0;
            perf_flush_cnt_out <= '0;
        end else begin
            if (held_c) begin
                perf_stall_cnt_out <= perf_stall_cnt_out + 32'(1);
            end
            if (jump_flag_out) begin
                perf_flush_cnt_out <= perf_flush_cnt_out + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl (FLUSH_CYCLES=1, HOLD_TIMEOUT=4); per-cycle expectations queued at drive time.
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_in;
    logic [31:0] jump_addr_in;
    logic        hold_ex_in;
    logic        hold_bus_in;
    logic        timeout_clr_in;
    logic        jump_flag_out;
    logic [31:0] jump_addr_out;
    logic        flush_out;
    logic [2:0]  hold_flag_out;
    logic        hold_timeout_out;
`ifdef CORE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_out;
    logic [31:0] perf_flush_cnt_out;
`endif

    core_ctrl #(
        .FLUSH_CYCLES (1),
        .HOLD_TIMEOUT (4),
        .CPU_RST_ADDR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .jump_flag_in     (jump_flag_in),
        .jump_addr_in     (jump_addr_in),
        .hold_ex_in       (hold_ex_in),
        .hold_bus_in      (hold_bus_in),
        .timeout_clr_in   (timeout_clr_in),
        .jump_flag_out    (jump_flag_out),
        .jump_addr_out    (jump_addr_out),
        .flush_out        (flush_out),
        .hold_flag_out    (hold_flag_out),
        .hold_timeout_out (hold_timeout_out)
`ifdef CORE_CTRL_PERF_EN
        ,
        .perf_stall_cnt_out (perf_stall_cnt_out),
        .perf_flush_cnt_out (perf_flush_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        jf;
        logic [31:0] addr;
        logic        fl;
        logic [2:0]  hold;
        logic        tmo;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_stall = 0;
    int   exp_jumps = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Compare every queued cycle on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_eq({mon_e.tag, "_jf"},    32'(jump_flag_out),    32'(mon_e.jf));
            check_eq({mon_e.tag, "_flush"}, 32'(flush_out),        32'(mon_e.fl));
            check_eq({mon_e.tag, "_hold"},  32'(hold_flag_out),    32'(mon_e.hold));
            check_eq({mon_e.tag, "_tmo"},   32'(hold_timeout_out), 32'(mon_e.tmo));
            if (mon_e.jf) begin
                check_eq({mon_e.tag, "_addr"}, jump_addr_out, mon_e.addr);
            end
        end
    end

    // One clock cycle: drive inputs just after a rising edge, queue the expectation, advance.
    task automatic step(input string tag, input logic jf, input logic [31:0] a,
                        input logic hex, input logic hbus, input logic clr,
                        input logic e_jf, input logic [31:0] e_addr, input logic e_fl,
                        input logic [2:0] e_hold, input logic e_tmo);
        exp_t e;
        jump_flag_in   = jf;
        jump_addr_in   = a;
        hold_ex_in     = hex;
        hold_bus_in    = hbus;
        timeout_clr_in = clr;
        e.tag  = tag;
        e.jf   = e_jf;
        e.addr = e_addr;
        e.fl   = e_fl;
        e.hold = e_hold;
        e.tmo  = e_tmo;
        q.push_back(e);
        if (e_jf) exp_jumps++;
        if (e_hold != 3'd0) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        jump_flag_in   = 1'b0;
        jump_addr_in   = '0;
        hold_ex_in     = 1'b0;
        hold_bus_in    = 1'b0;
        timeout_clr_in = 1'b0;
        #3;
        check_eq("rst0_jf",    32'(jump_flag_out),    32'd0);
        check_eq("rst0_addr",  jump_addr_out,         32'd0);
        check_eq("rst0_flush", 32'(flush_out),        32'd0);
        check_eq("rst0_hold",  32'(hold_flag_out),    32'd0);
        check_eq("rst0_tmo",   32'(hold_timeout_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain jump with one extra flush cycle
        step("t2_jump",  1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 3'd0, 1'b0);
        step("t2_flush", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0, 1'b0);
        step("t2_idle",  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0);

        // Async reset in the middle of a flush, with live requests on the inputs
        step("t1_jump",  1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 3'd0, 1'b0);
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h44;
        hold_ex_in   = 1'b1;
        #2;
        rst = 1'b0;
        exp_stall = 0;
        exp_jumps = 0;
        #1;
        check_eq("t1_rst_jf",    32'(jump_flag_out),    32'd0);
        check_eq("t1_rst_addr",  jump_addr_out,         32'd0);
        check_eq("t1_rst_flush", 32'(flush_out),        32'd0);
        check_eq("t1_rst_hold",  32'(hold_flag_out),    32'd0);
        check_eq("t1_rst_tmo",   32'(hold_timeout_out), 32'd0);
        jump_flag_in = 1'b0;
        jump_addr_in = '0;
        hold_ex_in   = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("t1_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);

        // Deferred jump behind a 3-cycle bus hold; 4 held cycles also trip the watchdog
        step("t3_c0", 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 1'b0);
        step("t3_c1", 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 1'b0);
        step("t3_c2", 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 1'b0);
        step("t3_c3", 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 3'd1, 1'b0);
        step("t3_c4", 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd0, 1'b1);
        step("t3_c5", 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b0);

        // Hold priority, flush counter reload, jump issued under an execute hold
        step("t4_both", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 3'd3, 1'b0);
        step("t4_bus",  1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 3'd1, 1'b0);
        step("t4_none", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0);
        step("t4_j1",   1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 3'd0, 1'b0);
        step("t4_j2",   1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 3'd0, 1'b0);
        step("t4_fl",   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0, 1'b0);
        step("t4_idle", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0);
        step("t4_jex",  1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 3'd3, 1'b0);
        step("t4_jexf", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0, 1'b0);
        step("t4_end",  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0);

        // Watchdog: 6 held cycles, flag visible from the 5th; then clear
        for (int i = 0; i < 6; i++) begin
            step($sformatf("t5_h%0d", i), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0,
                 1'b0, 32'h0, 1'b0, 3'd3, (i >= 4) ? 1'b1 : 1'b0);
        end
        step("t5_rel", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b1);
        step("t5_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b1);
        step("t5_cln", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);

        // Clear beats a simultaneous set
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t5p_h%0d", i), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0,
                 1'b0, 32'h0, 1'b0, 3'd3, 1'b0);
        end
        step("t5p_clr",  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd3, 1'b1);
        step("t5p_rel",  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        step("t5p_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);

        check_eq("sb_drained", 32'(q.size()), 32'd0);
`ifdef CORE_CTRL_PERF_EN
        check_eq("perf_flush", perf_flush_cnt_out, 32'(exp_jumps));
        check_eq("perf_stall", perf_stall_cnt_out, 32'(exp_stall));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
